// File: rtl/unpacking.sv
// 9-to-7 bit stream width converter, LSB-first.
// Inverse of the 7-to-9 packer on the receive side of the link.
module unpacking (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       drop,
  output logic [6:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [14:0] acc;
  logic [14:0] acc_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [14:0] keep;
  logic [14:0] ins;
  logic        push;
  logic        pop;

  assign out_valid = (cnt >= 4'd7);
  assign in_ready  = (cnt < 4'd7);
  assign out_data  = acc[6:0];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Stale bits above cnt are masked off before the new word lands.
  assign keep = (15'd1 << cnt) - 15'd1;
  assign ins  = {6'd0, in_data} << cnt;

  always_comb begin
    acc_n = acc;
    cnt_n = cnt;
    if (drop) begin
      acc_n = '0;
      cnt_n = '0;
    end else if (push) begin
      acc_n = (acc & keep) | ins;
      cnt_n = cnt + 4'd9;
    end else if (pop) begin
      acc_n = acc >> 7;
      cnt_n = cnt - 4'd7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_unpacking.sv
// Directed bench for the 9-to-7 unpacker.
// Expected values are hand-derived from the bit stream.
module tb_unpacking;

  logic       clk;
  logic       rst_n;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       drop;
  logic [6:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int n_checks;
  int n_fail;

  unpacking dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .drop      (drop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] w);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) check("push_timeout", 16'd0, 16'd1);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_drop();
    drop = 1'b1;
    step();
    drop = 1'b0;
  endtask

  task automatic run_stream(input logic [62:0] bits);
    int ni;
    int no;
    ni = 0;
    no = 0;
    for (int c = 0; c < 1000 && (ni < 7 || no < 9); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (ni < 7) && ($urandom_range(0, 2) != 0);
      in_data   = (ni < 7) ? bits[ni*9 +: 9] : 9'd0;
      if (out_valid && out_ready) begin
        if (no < 9) check("rt_slice", 16'(out_data), 16'(bits[no*7 +: 7]));
        no++;
      end
      if (in_valid && in_ready) ni++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rt_inputs", 16'(ni), 16'd7);
    check("rt_outputs", 16'(no), 16'd9);
    check("rt_cnt", 16'(dut.cnt), 16'd0);
    check("rt_ovalid", 16'(out_valid), 16'd0);
  endtask

  logic [6:0]  words [9];
  logic [62:0] packed_bits;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    drop      = 1'b0;
    out_ready = 1'b0;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      in_data   = 9'($urandom);
      in_valid  = 1'($urandom);
      drop      = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    check("rst_ovalid", 16'(out_valid), 16'd0);
    check("rst_iready", 16'(in_ready), 16'd1);
    check("rst_odata", 16'(out_data), 16'h00);
    in_valid  = 1'b0;
    in_data   = '0;
    drop      = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    step();
    step();
    check("idle_ovalid", 16'(out_valid), 16'd0);
    check("idle_iready", 16'(in_ready), 16'd1);
    check("idle_odata", 16'(out_data), 16'h00);

    // Single word
    out_ready = 1'b1;
    push(9'h1C7);
    check("sw1_ovalid", 16'(out_valid), 16'd1);
    check("sw1_odata", 16'(out_data), 16'h47);
    step();
    check("sw1_pop_ovalid", 16'(out_valid), 16'd0);
    check("sw1_cnt", 16'(dut.cnt), 16'd2);
    push(9'h000);
    check("sw2_odata", 16'(out_data), 16'h03);
    step();
    check("sw2_cnt", 16'(dut.cnt), 16'd4);
    check("sw2_ovalid", 16'(out_valid), 16'd0);

    // Backpressure
    out_ready = 1'b0;
    do_drop();
    push(9'h1C7);
    for (int i = 0; i < 5; i++) begin
      check("bp_odata", 16'(out_data), 16'h47);
      check("bp_ovalid", 16'(out_valid), 16'd1);
      check("bp_iready", 16'(in_ready), 16'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_pop_iready", 16'(in_ready), 16'd1);
    check("bp_pop_ovalid", 16'(out_valid), 16'd0);

    // Full buffer: walk cnt 0->9->2->11->4->13->6
    do_drop();
    for (int i = 0; i < 3; i++) begin
      push(9'h000);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("fb_cnt6", 16'(dut.cnt), 16'd6);
    push(9'h1FF);
    check("fb_cnt15", 16'(dut.cnt), 16'd15);
    check("fb_iready", 16'(in_ready), 16'd0);
    check("fb_odata0", 16'(out_data), 16'h40);
    out_ready = 1'b1;
    step();
    check("fb_odata1", 16'(out_data), 16'h7F);
    check("fb_cnt8", 16'(dut.cnt), 16'd8);
    step();
    out_ready = 1'b0;
    check("fb_cnt1", 16'(dut.cnt), 16'd1);
    check("fb_iready1", 16'(in_ready), 16'd1);

    // Drop mid-frame with a concurrent push
    do_drop();
    out_ready = 1'b1;
    push(9'h1C7);
    step();
    out_ready = 1'b0;
    check("dr_cnt2", 16'(dut.cnt), 16'd2);
    drop     = 1'b1;
    in_valid = 1'b1;
    in_data  = 9'h0AA;
    step();
    drop     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    check("dr_cnt0", 16'(dut.cnt), 16'd0);
    check("dr_ovalid", 16'(out_valid), 16'd0);
    check("dr_iready", 16'(in_ready), 16'd1);
    push(9'h1C7);
    check("dr_odata", 16'(out_data), 16'h47);
    check("dr_ovalid2", 16'(out_valid), 16'd1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ovalid", 16'(out_valid), 16'd0);
    check("ar_iready", 16'(in_ready), 16'd1);
    check("ar_odata", 16'(out_data), 16'h00);
    step();
    rst_n = 1'b1;
    step();

    // Round trip on the fixed pattern
    run_stream(63'h5A5A_F00F_1234_ABCD);

    // Round trip through a packed stream of random 7-bit words
    for (int i = 0; i < 9; i++) begin
      words[i] = 7'($urandom);
      packed_bits[i*7 +: 7] = words[i];
    end
    run_stream(packed_bits);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
